seq_restoring_divider: RTL and testbench
========================================

# seq_restoring_divider

Sequential unsigned integer divider, the inverse companion of the team's combinational array multiplier. It computes quotient and remainder of two WIDTH-bit operands by restoring division, one quotient bit per clock, behind a start/done handshake. It sits in the HW arithmetic datapath, next to the multiplier, so that a product can be divided back for cross-checking.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator, captured when start is accepted
- divisor  input  WIDTH  denominator, captured when start is accepted
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse; results valid in that cycle
- quotient  output  WIDTH  result, held until next accepted start
- remainder  output  WIDTH  result, held until next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with results

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start=1 accepts; dividend/divisor are captured into internal registers; inputs are then don't-care until the next accept.
- Accept with divisor≠0: go to CALC; load the partial remainder (WIDTH+1 bits) with 0, the quotient shift register with dividend, iteration counter with 0.
- Accept with divisor=0: go directly to DONE; quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC iteration, once per cycle: shift {rem, q} left 1 with the q MSB entering rem LSB; trial = rem − {0,divisor} in WIDTH+1 bits; if trial ≥ 0 (MSB=0), rem=trial and q LSB=1, else rem is restored and q LSB=0.
- After exactly WIDTH iterations, go to DONE. Write quotient=q and remainder=rem[WIDTH-1:0], and clear div_by_zero.
- DONE: done=1 for exactly one cycle, then go unconditionally to IDLE.
- start while busy=1 (CALC or DONE) is ignored; no queueing.
- Results and div_by_zero are not cleared on return to IDLE. They change only at the next completion or on reset.
- Invariant for nonzero divisor: dividend = quotient·divisor + remainder, remainder < divisor.

## Timing
- Reset (async assert, synchronous-to-clk release assumed upstream): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers 0.
- Reset mid-CALC or in DONE: the operation is aborted immediately, with no done pulse; outputs take their reset values.
- start accepted at edge k, divisor≠0:
  - CALC iterations occur on edges k+1 … k+WIDTH.
  - done=1 in the cycle after edge k+WIDTH, giving latency WIDTH+1 cycles from accept.
- start accepted at edge k, divisor=0: done=1 in the cycle after edge k, giving latency 1.
- busy rises in the cycle after accept and falls in the cycle after done.
- The earliest next accept is the first edge where the state is IDLE, i.e. the edge following the done cycle.
- Throughput: one division per WIDTH+2 cycles for a nonzero divisor.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, dividend=13, divisor=3, start pulse -> done exactly 5 cycles after accept; quotient=4, remainder=1, div_by_zero=0; busy high for 5 cycles.
- dividend=7, divisor=0 -> done 1 cycle after accept; quotient=15, remainder=7, div_by_zero=1. A following 15/15 gives quotient=1, remainder=0, div_by_zero=0.
- dividend=5, divisor=10 -> quotient=0, remainder=5. Change dividend/divisor inputs during CALC -> result is unaffected.
- Start 9/2, hold start=1 throughout, and apply a 12/4 start pulse during CALC and during DONE -> only 9/2 completes (quotient=4, remainder=1); no second done until a new accept in IDLE.
- Start 15/1, assert rst_n=0 at the 2nd CALC cycle -> all outputs 0 immediately, no done pulse. After release, 15/1 gives quotient=15, remainder=0.
- Exhaustive check of all 256 (dividend, divisor) pairs with back-to-back starts -> every nonzero-divisor result satisfies dividend=quotient·divisor+remainder with remainder<divisor. Every zero-divisor result gives quotient=15, remainder=dividend, div_by_zero=1.

Source files
------------

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_if
// Description : Start/done handshake and operand/result bundle for the
//               sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_restoring_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider
// Description : Unsigned WIDTH-bit restoring divider, one quotient bit per
//               clock, with start/done handshake and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    seq_restoring_divider_if.slave bus
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    // Working registers. The partial remainder is always below the divisor
    // between iterations, so its stored form needs only WIDTH bits; the
    // extra bit exists only in the shifted/trial values.
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_divisor;
    logic [c_CNT_W-1:0] r_count;

    // Result registers, held until the next completion.
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_q_next;

    assign w_accept   = (r_state == c_IDLE) && bus.start;
    assign w_div_zero = (bus.divisor == '0);
    assign w_last     = (r_count == c_LAST);

    // One restoring step: shift in the next dividend bit, trial-subtract,
    // keep the difference only if it did not go negative.
    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};
    assign w_rem_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: zero divisor skips the iteration phase entirely.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_div_zero ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (w_last) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem         <= '0;
            r_q           <= '0;
            r_divisor     <= '0;
            r_count       <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_rem     <= '0;
            r_q       <= bus.dividend;
            r_divisor <= bus.divisor;
            r_count   <= '0;
            if (w_div_zero) begin
                r_quotient    <= '1;
                r_remainder   <= bus.dividend;
                r_div_by_zero <= 1'b1;
            end
        end else if (r_state == c_CALC) begin
            r_rem   <= w_rem_next;
            r_q     <= w_q_next;
            r_count <= r_count + c_CNT_W'(1);
            if (w_last) begin
                r_quotient    <= w_q_next;
                r_remainder   <= w_rem_next;
                r_div_by_zero <= 1'b0;
            end
        end
    end

    assign bus.busy        = (r_state != c_IDLE);
    assign bus.done        = (r_state == c_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Directed self-checking bench for seq_restoring_divider
//               (WIDTH=4), plus a sweep over all operand pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   lat;
    int   bcyc;

    seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands with start high until the divider shows busy
    // (i.e. the request was accepted); returns just after the accepting edge.
    task automatic do_div(input int dd, input int ds);
        int n;
        n = 0;
        bus.dividend = 4'(dd);
        bus.divisor  = 4'(ds);
        bus.start    = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.busy !== 1'b1 && n < 4);
        bus.start = 1'b0;
        chk("accept", 32'(bus.busy), 32'd1);
    endtask

    // Count edges from the accept until done is seen, and busy cycles.
    task automatic wait_done(output int l, output int b);
        l = 0;
        b = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && l < 20) begin
            @(posedge clk); #1;
            l++;
            if (bus.busy === 1'b1) b++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int ndone;
        n_checks = 0;
        n_errors = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q",    32'(bus.quotient), 32'd0);
        chk("rst_r",    32'(bus.remainder), 32'd0);
        chk("rst_dbz",  32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 13 / 3 = 4 r 1: done after WIDTH edges past the accept edge,
        // i.e. 5 cycles counting the accept cycle; busy for 5 cycles.
        do_div(13, 3);
        wait_done(lat, bcyc);
        chk("t1_lat",  32'(lat), 32'd4);
        chk("t1_busy", 32'(bcyc), 32'd5);
        chk("t1_q",    32'(bus.quotient), 32'd4);
        chk("t1_r",    32'(bus.remainder), 32'd1);
        chk("t1_dbz",  32'(bus.div_by_zero), 32'd0);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(bus.done), 32'd0);
        chk("t1_busy_fall",  32'(bus.busy), 32'd0);

        // 7 / 0: immediate completion with flag
        do_div(7, 0);
        chk("t2_done_now", 32'(bus.done), 32'd1);
        wait_done(lat, bcyc);
        chk("t2_lat", 32'(lat), 32'd0);
        chk("t2_q",   32'(bus.quotient), 32'd15);
        chk("t2_r",   32'(bus.remainder), 32'd7);
        chk("t2_dbz", 32'(bus.div_by_zero), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_hold_q",   32'(bus.quotient), 32'd15);
        chk("t2_hold_dbz", 32'(bus.div_by_zero), 32'd1);

        // 15 / 15 = 1 r 0, clears the flag
        do_div(15, 15);
        wait_done(lat, bcyc);
        chk("t3_q",   32'(bus.quotient), 32'd1);
        chk("t3_r",   32'(bus.remainder), 32'd0);
        chk("t3_dbz", 32'(bus.div_by_zero), 32'd0);

        // 5 / 10 = 0 r 5, operands disturbed during CALC
        do_div(5, 10);
        bus.dividend = 4'd15;
        bus.divisor  = 4'd1;
        wait_done(lat, bcyc);
        chk("t4_q", 32'(bus.quotient), 32'd0);
        chk("t4_r", 32'(bus.remainder), 32'd5);

        // 9 / 2 with start held; 12 / 4 offered during CALC and DONE
        @(posedge clk); #1;
        bus.dividend = 4'd9;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        chk("t5_accept", 32'(bus.busy), 32'd1);
        bus.dividend = 4'd12;
        bus.divisor  = 4'd4;
        wait_done(lat, bcyc);
        chk("t5_lat", 32'(lat), 32'd4);
        chk("t5_q",   32'(bus.quotient), 32'd4);
        chk("t5_r",   32'(bus.remainder), 32'd1);
        @(posedge clk); #1;
        chk("t5_idle", 32'(bus.busy), 32'd0);
        chk("t5_done_low", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        chk("t5_no_second_done", 32'(ndone), 32'd0);
        chk("t5_q_kept", 32'(bus.quotient), 32'd4);

        // 15 / 1 aborted by reset in the second CALC cycle
        do_div(15, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd0);
        chk("t6_q",    32'(bus.quotient), 32'd0);
        chk("t6_r",    32'(bus.remainder), 32'd0);
        chk("t6_dbz",  32'(bus.div_by_zero), 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        chk("t6_no_done", 32'(ndone), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_div(15, 1);
        wait_done(lat, bcyc);
        chk("t6_q_after", 32'(bus.quotient), 32'd15);
        chk("t6_r_after", 32'(bus.remainder), 32'd0);

        // All operand pairs, issued back to back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_div(a, b);
                wait_done(lat, bcyc);
                if (b != 0) begin
                    chk("sw_lat", 32'(lat), 32'd4);
                    chk("sw_identity", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
                    chk("sw_rem_lt", 32'(32'(bus.remainder) < 32'(b)), 32'd1);
                    chk("sw_dbz", 32'(bus.div_by_zero), 32'd0);
                end else begin
                    chk("sw_z_lat", 32'(lat), 32'd0);
                    chk("sw_z_q",   32'(bus.quotient), 32'd15);
                    chk("sw_z_r",   32'(bus.remainder), 32'(a));
                    chk("sw_z_dbz", 32'(bus.div_by_zero), 32'd1);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
